adc_frame_packer: RTL

- Downstream stage of the ADC trigger/capture block. Consumes its ready-less 64-bit sample stream: {sample_counter[48:0], sum_abs[14:0]}.
- Packs four 16-bit samples per 64-bit word.
- Prefixes each frame with a timestamp header word.
- Buffers words in an output FIFO and presents them on a backpressured AXI-Stream master toward the DMA/writer.
- Frames that cannot be buffered in full are dropped whole and counted.

---
 rtl/adc_pkg.sv | 34 +++
 rtl/adc_frame_packer_if.sv | 20 ++
 rtl/adc_frame_fifo.sv | 60 ++++++
 rtl/adc_frame_packer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
//   Shared definitions for the ADC frame packer:
//   - header magic and pad sample constants
//   - packer state encoding
//   - input stream field positions {timestamp, signed sample}
//   - FIFO word layout {last, data}
// ---------------------------------------------------------------------------
package adc_pkg;

   localparam logic [7:0]  HDR_MAGIC  = 8'hA5;
   localparam logic [15:0] PAD_SAMPLE = 16'h8000;

   localparam int TS_LSB   = 15;
   localparam int SAMPLE_W = 15;
   localparam int TS_W     = 64 - TS_LSB;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DISCARD
   } state_t;

   typedef struct packed {
      logic        last;
      logic [63:0] data;
   } fifo_word_t;

   // Widen the raw 15-bit signed sample to one 16-bit lane.
   function automatic logic [15:0] sext_sample(input logic [SAMPLE_W-1:0] raw);
      return {raw[SAMPLE_W-1], raw};
   endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// ---------------------------------------------------------------------------
// adc_frame_packer_if
//   AXI-Stream style word channel between the packer and the DMA/writer.
//   tdata  : packed word
//   tvalid : word available
//   tlast  : last word of a frame
//   tready : sink accepts the word
//   master modport drives tdata/tvalid/tlast, slave modport drives tready.
// ---------------------------------------------------------------------------
interface adc_frame_packer_if #(
   parameter int DW = 64
);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_frame_fifo.sv
// ---------------------------------------------------------------------------
// adc_frame_fifo
//   Synchronous first-word-fall-through FIFO, depth 2**AW.
//   aclk, aresetn : clock, async active-low reset (empties the FIFO)
//   push, wdata   : write one word (ignored when full)
//   pop           : consume the head word (ignored when empty)
//   rdata         : head word, zero while empty
//   empty, level  : occupancy status
// ---------------------------------------------------------------------------
module adc_frame_fifo #(
   parameter int DW = 65,
   parameter int AW = 7
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level   = wr_ptr - rd_ptr;
   assign empty   = (level == '0);
   assign full    = level[AW];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop
         // samples the pre-edge values regardless of statement order.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, which keeps the array mappable onto RAM.
   always_ff @(posedge aclk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/adc_frame_packer.sv
// ---------------------------------------------------------------------------
// adc_frame_packer
//   Packs a ready-less stream of 64-bit ADC records {ts[48:0], sample[14:0]}
//   into frames: one header word {A5, 7'd0, ts} followed by up to
//   WORDS_PER_FRAME payload words of four 16-bit samples, buffered in a FIFO
//   and presented on a backpressured AXI-Stream master.
//   aclk, aresetn        : clock, async active-low reset
//   s_axis_tvalid/tdata  : input records (always consumed)
//   flush                : close the open frame
//   m_axis               : output word stream (master modport)
//   frames_sent          : frames whose tlast word entered the FIFO
//   frames_dropped       : frames refused at admission
//   fifo_level           : FIFO occupancy
// ---------------------------------------------------------------------------
module adc_frame_packer
   import adc_pkg::*;
#(
   parameter int WORDS_PER_FRAME = 64,
   parameter int FIFO_AW         = 7
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    s_axis_tvalid,
   input  logic [63:0]             s_axis_tdata,
   input  logic                    flush,
   adc_frame_packer_if.master      m_axis,
   output logic [31:0]             frames_sent,
   output logic [31:0]             frames_dropped,
   output logic [FIFO_AW:0]        fifo_level
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int WCW   = $clog2(WORDS_PER_FRAME + 1);

   state_t            state, state_d;
   logic [1:0]        lane, lane_d;
   logic [WCW-1:0]    word_cnt, word_cnt_d;
   logic [TS_W-1:0]   prev_ts, prev_ts_d;
   logic [2:0][15:0]  lane_buf, lane_buf_d;
   logic              stage_v, stage_v_d;
   fifo_word_t        stage_w, stage_w_d;

   logic [15:0]       samp;
   logic [TS_W-1:0]   ts;
   logic              active, keep, gap, store, fill, last_word, close, start, admit;
   logic              wr_pay, wr_close;
   logic [3:0][15:0]  lanes_m;
   logic [2:0]        close_cnt;
   logic [63:0]       close_word;
   logic [1:0]        pre;
   logic [31:0]       need;
   fifo_word_t        cand [4];
   logic [3:0]        cand_v;
   logic              push;
   fifo_word_t        push_w;
   fifo_word_t        rd_w;
   logic              fifo_empty;

   assign samp   = sext_sample(s_axis_tdata[SAMPLE_W-1:0]);
   assign ts     = s_axis_tdata[63:TS_LSB];
   assign active = (state != IDLE);
   assign keep   = (state == COLLECT);

   // A discontinuous timestamp ends the open frame; the gapping sample then
   // opens a new one. A flush in the same cycle is absorbed by that close.
   assign gap       = active && s_axis_tvalid && (ts != prev_ts + {{(TS_W-1){1'b0}}, 1'b1});
   assign store     = active && s_axis_tvalid && !gap;
   assign fill      = store && (lane == 2'd3);
   assign last_word = fill && (word_cnt == WCW'(WORDS_PER_FRAME - 1));
   assign close     = active && !last_word && (gap || flush);
   assign start     = s_axis_tvalid && (!active || gap);
   assign wr_pay    = fill && keep;
   assign wr_close  = close && keep;

   // Lanes as they stand after this cycle's sample is stored.
   always_comb begin
      lanes_m[3] = samp;
      for (int k = 0; k < 3; k++) begin
         lanes_m[k] = (lane == 2'(k)) ? samp : lane_buf[k];
      end
   end

   // Close word keeps the filled lanes and pads the rest; if lane 3 just
   // filled, the payload word took the samples and the close is all pad.
   always_comb begin
      if (fill)       close_cnt = 3'd0;
      else if (store) close_cnt = {1'b0, lane} + 3'd1;
      else            close_cnt = {1'b0, lane};
      for (int k = 0; k < 4; k++) begin
         close_word[16*k +: 16] = (3'(k) < close_cnt) ? lanes_m[k] : PAD_SAMPLE;
      end
   end

   // Admission: room for header plus a full payload after every word already
   // committed ahead of the header. A header can only be staged into an empty
   // stage slot, which bounds pending writes to one per cycle.
   assign pre   = {1'b0, stage_v} + {1'b0, wr_pay} + {1'b0, wr_close};
   assign need  = 32'(fifo_level) + 32'(pre) + 32'(WORDS_PER_FRAME + 1);
   assign admit = start && (pre <= 2'd1) && (need <= 32'(DEPTH));

   // Write candidates in stream order; the first goes to the FIFO, the
   // second waits one cycle in the stage register.
   always_comb begin
      cand[0] = stage_w;
      cand[1] = '{last: last_word, data: lanes_m};
      cand[2] = '{last: 1'b1, data: close_word};
      cand[3] = '{last: 1'b0, data: {HDR_MAGIC, 7'd0, ts}};
      cand_v  = {admit, wr_close, wr_pay, stage_v};
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // through the block leaves a value unassigned and infers a latch.
      push      = 1'b0;
      push_w    = '0;
      stage_v_d = 1'b0;
      stage_w_d = '0;
      for (int i = 0; i < 4; i++) begin
         if (cand_v[i]) begin
            if (!push) begin
               push   = 1'b1;
               push_w = cand[i];
            end else if (!stage_v_d) begin
               stage_v_d = 1'b1;
               stage_w_d = cand[i];
            end
         end
      end
   end

   // Next-state and frame-tracking logic.
   always_comb begin
      state_d    = state;
      lane_d     = lane;
      word_cnt_d = word_cnt;
      prev_ts_d  = prev_ts;
      lane_buf_d = lane_buf;
      if (start) begin
         state_d       = admit ? COLLECT : DISCARD;
         lane_d        = 2'd1;
         word_cnt_d    = '0;
         lane_buf_d[0] = samp;
         prev_ts_d     = ts;
      end else if (store) begin
         lane_d    = lane + 2'd1;
         prev_ts_d = ts;
         for (int k = 0; k < 3; k++) begin
            if (lane == 2'(k)) lane_buf_d[k] = samp;
         end
         if (fill) begin
            word_cnt_d = word_cnt + 1'b1;
            if (last_word) begin
               state_d    = IDLE;
               word_cnt_d = '0;
            end
         end
      end
      if (close && !gap) begin
         state_d    = IDLE;
         lane_d     = 2'd0;
         word_cnt_d = '0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state          <= IDLE;
         lane           <= '0;
         word_cnt       <= '0;
         prev_ts        <= '0;
         lane_buf       <= '0;
         stage_v        <= 1'b0;
         stage_w        <= '0;
         frames_sent    <= '0;
         frames_dropped <= '0;
      end else begin
         state    <= state_d;
         lane     <= lane_d;
         word_cnt <= word_cnt_d;
         prev_ts  <= prev_ts_d;
         lane_buf <= lane_buf_d;
         stage_v  <= stage_v_d;
         stage_w  <= stage_w_d;
         if (push && push_w.last) frames_sent    <= frames_sent + 32'd1;
         if (start && !admit)     frames_dropped <= frames_dropped + 32'd1;
      end
   end

   adc_frame_fifo #(
      .DW (65),
      .AW (FIFO_AW)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .push    (push),
      .wdata   (push_w),
      .pop     (m_axis.tvalid && m_axis.tready),
      .rdata   (rd_w),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign m_axis.tvalid = !fifo_empty;
   assign m_axis.tdata  = rd_w.data;
   assign m_axis.tlast  = rd_w.last;

endmodule
